// File: rtl/debug_step_ctrl.sv
// Single-step run control: freezes the pipeline in debug mode and releases it for one commit per
// step-button press. The optional step watchdog is enabled by defining DEBUG_STEP_WATCHDOG_EN.
module debug_step_ctrl #(
    parameter int unsigned STEP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        debug_flag,
    input  logic        debug_step,
    input  logic        commit_valid,
    output logic        cpu_stall,
    output logic [1:0]  step_state,
    output logic        step_done,
    output logic [15:0] step_count,
    output logic        step_timeout
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StHalt    = 2'd1,
        StStep    = 2'd2,
        StWaitRel = 2'd3
    } state_e;

    if (STEP_TIMEOUT < 2 || STEP_TIMEOUT > 65535) begin : g_bad_timeout
        $error("debug_step_ctrl: STEP_TIMEOUT must be in 2..65535");
    end

    state_e      state_q;
    logic        step_q;
    logic        done_q;
    logic [15:0] count_q;
    logic        step_rise;

    assign step_rise = debug_step & ~step_q;

`ifdef DEBUG_STEP_WATCHDOG_EN
    localparam logic [15:0] WdogLast = 16'(STEP_TIMEOUT - 1);

    logic [15:0] wdog_q;
    logic        timeout_q;
    logic        wdog_expired;

    assign wdog_expired = (wdog_q == WdogLast);
    assign step_timeout = timeout_q;
`else
    assign step_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StRun;
            step_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= 16'd0;
`ifdef DEBUG_STEP_WATCHDOG_EN
            wdog_q    <= 16'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            step_q <= debug_step;
            done_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (debug_flag) state_q <= StHalt;
                end
                StHalt: begin
                    if (!debug_flag) begin
                        state_q <= StRun;
                    end else if (step_rise) begin
                        state_q   <= StStep;
`ifdef DEBUG_STEP_WATCHDOG_EN
                        wdog_q    <= 16'd0;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                StStep: begin
                    // A commit counts even when debug mode is dropped on the same edge.
                    if (commit_valid) begin
                        count_q <= count_q + 16'd1;
                        done_q  <= 1'b1;
                    end
                    if (!debug_flag) begin
                        state_q <= StRun;
                    end else if (commit_valid) begin
                        state_q <= StWaitRel;
                    end
`ifdef DEBUG_STEP_WATCHDOG_EN
                    else if (wdog_expired) begin
                        state_q   <= StWaitRel;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
`endif
                end
                StWaitRel: begin
                    if (!debug_flag) begin
                        state_q <= StRun;
                    end else if (!debug_step) begin
                        state_q <= StHalt;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign cpu_stall  = (state_q == StHalt) || (state_q == StWaitRel);
    assign step_state = state_q;
    assign step_done  = done_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Scoreboard bench for debug_step_ctrl: each driven cycle pushes its expected outputs, which are
// popped and compared after the clock edge. Watchdog checks follow DEBUG_STEP_WATCHDOG_EN.
module tb_debug_step_ctrl;

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StHalt    = 2'd1;
    localparam logic [1:0] StStep    = 2'd2;
    localparam logic [1:0] StWaitRel = 2'd3;

    typedef struct packed {
        logic [1:0]  st;
        logic        dn;
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        debug_flag;
    logic        debug_step;
    logic        commit_valid;
    logic        cpu_stall;
    logic [1:0]  step_state;
    logic        step_done;
    logic [15:0] step_count;
    logic        step_timeout;

    exp_t        sb[$];
    logic [15:0] cnt;
    string       phase;
    int          total;
    int          bad;

    debug_step_ctrl #(
        .STEP_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .debug_flag  (debug_flag),
        .debug_step  (debug_step),
        .commit_valid(commit_valid),
        .cpu_stall   (cpu_stall),
        .step_state  (step_state),
        .step_done   (step_done),
        .step_count  (step_count),
        .step_timeout(step_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_state", 32'(step_state), 32'(StRun));
        check_eq("rst_stall", 32'(cpu_stall), 32'd0);
        check_eq("rst_done", 32'(step_done), 32'd0);
        check_eq("rst_count", 32'(step_count), 32'd0);
        check_eq("rst_timeout", 32'(step_timeout), 32'd0);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
    task automatic cyc(input logic f, input logic b, input logic c,
                       input logic [1:0] st, input logic dn, input logic to);
        exp_t e;
        debug_flag   = f;
        debug_step   = b;
        commit_valid = c;
        e.st  = st;
        e.dn  = dn;
        e.cnt = cnt;
        e.to  = to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq("state", 32'(step_state), 32'(e.st));
            check_eq("stall", 32'(cpu_stall), 32'((e.st == StHalt) || (e.st == StWaitRel)));
            check_eq("done", 32'(step_done), 32'(e.dn));
            check_eq("count", 32'(step_count), 32'(e.cnt));
            check_eq("timeout", 32'(step_timeout), 32'(e.to));
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        cnt          = 16'd0;
        phase        = "reset";
        rstn         = 1'b0;
        debug_flag   = 1'b0;
        debug_step   = 1'b0;
        commit_valid = 1'b0;
        #7;
        check_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;
        cyc(0, 0, 0, StRun, 0, 0);

        phase = "halt_step";
        cyc(1, 0, 0, StHalt, 0, 0);
        cyc(1, 0, 0, StHalt, 0, 0);
        cyc(1, 1, 0, StStep, 0, 0);
        cyc(1, 1, 0, StStep, 0, 0);
        cyc(1, 1, 0, StStep, 0, 0);
        cnt = cnt + 16'd1;
        cyc(1, 1, 1, StWaitRel, 1, 0);
        cyc(1, 1, 0, StWaitRel, 0, 0);
        cyc(1, 0, 0, StHalt, 0, 0);

        phase = "held";
        cyc(1, 1, 1, StStep, 0, 0);
        cnt = cnt + 16'd1;
        cyc(1, 1, 1, StWaitRel, 1, 0);
        for (int i = 0; i < 198; i++) cyc(1, 1, 1, StWaitRel, 0, 0);
        cyc(1, 0, 0, StHalt, 0, 0);
        cyc(1, 0, 0, StHalt, 0, 0);

        phase = "watchdog";
`ifdef DEBUG_STEP_WATCHDOG_EN
        cyc(1, 1, 0, StStep, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 1, 0, StStep, 0, 0);
        cyc(1, 1, 0, StWaitRel, 0, 1);
        cyc(1, 1, 0, StWaitRel, 0, 1);
        cyc(1, 0, 0, StHalt, 0, 1);
        cyc(1, 1, 0, StStep, 0, 0);
        cnt = cnt + 16'd1;
        cyc(1, 1, 1, StWaitRel, 1, 0);
`else
        cyc(1, 1, 0, StStep, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, StStep, 0, 0);
        cnt = cnt + 16'd1;
        cyc(1, 1, 1, StWaitRel, 1, 0);
`endif
        cyc(1, 0, 0, StHalt, 0, 0);

        phase = "exit_step";
        cyc(1, 1, 0, StStep, 0, 0);
        cnt = cnt + 16'd1;
        cyc(0, 1, 1, StRun, 1, 0);
        cyc(0, 0, 0, StRun, 0, 0);

        phase = "held_entry";
        cyc(0, 1, 0, StRun, 0, 0);
        cyc(1, 1, 0, StHalt, 0, 0);
        cyc(1, 1, 0, StHalt, 0, 0);
        cyc(1, 1, 0, StHalt, 0, 0);
        cyc(1, 0, 0, StHalt, 0, 0);

        phase = "wrap";
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        cnt = 16'hFFFF;
        cyc(1, 0, 0, StHalt, 0, 0);
        cyc(1, 1, 0, StStep, 0, 0);
        cnt = cnt + 16'd1;
        cyc(1, 1, 1, StWaitRel, 1, 0);

        phase = "reset_mid_step";
        cyc(1, 0, 0, StHalt, 0, 0);
        cyc(1, 1, 0, StStep, 0, 0);
        cnt = cnt + 16'd1;
        cyc(1, 1, 1, StWaitRel, 1, 0);
        cyc(1, 0, 0, StHalt, 0, 0);
        cyc(1, 1, 0, StStep, 0, 0);
        rstn = 1'b0;
        #2;
        check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cnt  = 16'd0;
        cyc(0, 0, 0, StRun, 0, 0);
        cyc(0, 0, 0, StRun, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_step_ctrl.md
# debug_step_ctrl

Run-control stage directly downstream of the debug breakpoint/flag logic. It consumes the level `debug_flag` and the debounced `debug_step` button and produces the pipeline-wide `cpu_stall`. While debug mode is active, each press of the step button lets exactly one instruction commit before the core is frozen again. It also keeps a step counter and an optional step watchdog, both visible on the debug display.

## Interface
- `STEP_TIMEOUT`, default 1024: cycles STEP may wait for a commit before the watchdog aborts it (only with the watchdog macro). Legal range 2..65535.
- `clk`  in  1  system clock
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low
- `debug_flag`  in  1  level; 1 = debug mode requested (from breakpoint/flag stage)
- `debug_step`  in  1  debounced step button level
- `commit_valid`  in  1  one instruction retired this cycle (same signal as cosim_valid)
- `cpu_stall`  out  1  freeze whole pipeline (PC, all stage registers, memory requests)
- `step_state`  out  2  FSM state: 0 RUN, 1 HALT, 2 STEP, 3 WAIT_REL
- `step_done`  out  1  one-cycle pulse: the stepped instruction committed
- `step_count`  out  16  number of completed steps since reset
- `step_timeout`  out  1  sticky: last step aborted by watchdog (0 when watchdog compiled out)

## Operation
- Edge detect: `step_q` is the registered copy of `debug_step`. `step_rise = debug_step & ~step_q`.
- FSM (Moore; `cpu_stall` = state is HALT or WAIT_REL):
  - RUN: `debug_flag`=1 → HALT.
  - HALT: `debug_flag`=0 → RUN. Else `step_rise` → STEP, which clears `step_timeout` and the watchdog counter.
  - STEP: `debug_flag`=0 → RUN; if `commit_valid` is also 1, the step still counts. Else `commit_valid` → WAIT_REL, with `step_done`=1 and `step_count`+1. Else watchdog expiry → WAIT_REL with `step_timeout`←1, no count.
  - WAIT_REL: `debug_flag`=0 → RUN. Else `debug_step`=0 → HALT.
- `debug_flag`=0 has priority over every other transition in every state.
- Holding the button gives one step only. A new step needs a release (WAIT_REL→HALT) and then a new rising edge.
- If the button is already held when entering HALT from RUN, no step is taken: `step_q`=1, so there is no rise.
- `step_count` is a 16-bit counter and wraps 0xFFFF→0x0000.
- `step_done` is registered: asserted during the first WAIT_REL (or RUN) cycle that follows the counted commit.

## Timing
- Reset (asynchronous, any state, mid-step included): state RUN, `cpu_stall`=0, `step_done`=0, `step_count`=0, `step_timeout`=0, `step_q`=0, watchdog counter 0.
- Flag to stall: `debug_flag` sampled 1 at edge N gives `cpu_stall`=1 from cycle N+1. An instruction committing in cycle N is allowed.
- Button to release: `step_rise` sampled at edge N gives `cpu_stall`=0 from cycle N+1.
- Commit to re-freeze: commit sampled at edge M gives `cpu_stall`=1 from cycle M+1. Exactly one commit per step, given the core retires at most one instruction per cycle and does not retire while stalled.
- Watchdog: counts STEP cycles without a commit. When the count reaches `STEP_TIMEOUT`-1 with no commit, the FSM takes the abort transition on that edge.
- Flag and commit on the same edge in STEP: go to RUN, `step_count`+1, `step_done` pulses.

## Configuration
- `DEBUG_STEP_WATCHDOG_EN` defined: watchdog counter (16 bits) and `step_timeout` logic are present.
- Not defined: STEP waits indefinitely for a commit, `step_timeout` is tied to 0, and `STEP_TIMEOUT` is ignored.

## Test plan
- Reset mid-STEP: assert `rstn`=0 asynchronously → outputs go to reset values immediately, with no clock needed. After release, state is RUN and `cpu_stall`=0.
- Halt then step: raise `debug_flag`; press `debug_step`; pulse `commit_valid` 3 cycles after the press.
  - `cpu_stall` is 1 from the cycle after the flag.
  - `cpu_stall` is 0 from the cycle after the press.
  - `cpu_stall` returns to 1 the cycle after the commit; `step_done` pulses once; `step_count`=1.
- Held button: press for 200 cycles while `commit_valid` is 1 every cycle → exactly one step (`step_count`=1). State stays WAIT_REL until release, then goes to HALT.
- Exit during STEP: drop `debug_flag` in the same cycle as `commit_valid` → state RUN, `cpu_stall`=0, `step_count`+1.
- Watchdog (macro on, `STEP_TIMEOUT`=8): step with no commit → at cycle 8 the state goes to WAIT_REL, `step_timeout`=1, `step_count` unchanged. The next step press clears `step_timeout`.
- Counter wrap: preload 0xFFFF steps (or force) and do one more step → `step_count`=0x0000.
